// File: rtl/ext_int_cond.sv
// ext_int_cond: synchronizes, optionally debounces and conditions external interrupt pins
// into a pending vector with a registered any-flag and lowest-index priority id.
module ext_int_cond #(
  parameter int NUM_LINES = 31,
  parameter int DEB_DIV   = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_LINES-1:0] pin_in,
  input  logic                 deb_en,
  input  logic [NUM_LINES-1:0] mode,
  input  logic                 clr_valid,
  input  logic [NUM_LINES-1:0] clr_mask,
  output logic [NUM_LINES-1:0] ext_int_out,
  output logic                 int_any,
  output logic [4:0]           int_id
);
  logic [NUM_LINES-1:0] sync1, sync2, samp, filt, filt_d, pending;
  logic [NUM_LINES-1:0] filt_nxt, pend_nxt, clr;
  logic [15:0]          cnt;
  logic                 tick;
  logic [4:0]           id_nxt;
  assign tick = cnt == 16'(DEB_DIV - 1);
  assign ext_int_out = pending;
  always_comb begin
    clr = clr_valid ? clr_mask : '0;
    // a line only moves when two consecutive tick samples agree
    filt_nxt = !deb_en ? sync2 : tick ? (~(sync2 ^ samp) & sync2) | ((sync2 ^ samp) & filt) : filt;
    // edge lines: set beats clear; level lines follow filt
    pend_nxt = (~mode & filt) | (mode & ((filt & ~filt_d) | (pending & ~clr)));
    id_nxt = '0;
    for (int i = NUM_LINES - 1; i >= 0; i--)
      if (pending[i]) id_nxt = 5'(i);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1   <= '0;
      sync2   <= '0;
      samp    <= '0;
      filt    <= '0;
      filt_d  <= '0;
      pending <= '0;
      cnt     <= '0;
      int_any <= 1'b0;
      int_id  <= '0;
    end else begin
      sync1   <= pin_in;
      sync2   <= sync1;
      if (!deb_en || tick) samp <= sync2;
      filt    <= filt_nxt;
      filt_d  <= filt;
      pending <= pend_nxt;
      cnt     <= tick ? '0 : cnt + 16'd1;
      int_any <= |pending;
      int_id  <= id_nxt;
    end
  end
endmodule

// File: tb/tb_ext_int_cond.sv
// tb_ext_int_cond: directed stimulus with a behavioural reference model checked every cycle.
module tb_ext_int_cond;
  localparam int N = 31;
  localparam int D = 16;
  logic         clk = 0;
  logic         rst_n = 0;
  logic [N-1:0] pin_in = '0, mode = '0, clr_mask = '0;
  logic         deb_en = 0, clr_valid = 0;
  logic [N-1:0] ext_int_out;
  logic         int_any;
  logic [4:0]   int_id;
  int nvec = 0, miss = 0;

  ext_int_cond #(.NUM_LINES(N), .DEB_DIV(D)) dut (
    .clk(clk), .rst_n(rst_n), .pin_in(pin_in), .deb_en(deb_en), .mode(mode),
    .clr_valid(clr_valid), .clr_mask(clr_mask), .ext_int_out(ext_int_out),
    .int_any(int_any), .int_id(int_id));

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      miss++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [4:0] lowest(input logic [N-1:0] v);
    for (int i = 0; i < N; i++) if (v[i]) return 5'(i);
    return 5'd0;
  endfunction

  // reference model: pins seen two samples late, debounce on every D-th edge since reset
  logic [N-1:0] h1 = '0, h2 = '0, m_filt = '0, m_prev = '0, m_last = '0, m_pend = '0;
  logic         m_any = 0;
  logic [4:0]   m_id = '0;
  int           cyc = 0;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h1 <= '0; h2 <= '0; m_filt <= '0; m_prev <= '0; m_last <= '0; m_pend <= '0;
      m_any <= 0; m_id <= '0; cyc <= 0;
    end else begin
      h1 <= pin_in;
      h2 <= h1;
      if (!deb_en) begin
        m_filt <= h2;
        m_last <= h2;
      end else if (cyc % D == D - 1) begin
        for (int i = 0; i < N; i++) if (h2[i] == m_last[i]) m_filt[i] <= h2[i];
        m_last <= h2;
      end
      m_prev <= m_filt;
      for (int i = 0; i < N; i++)
        if (!mode[i]) m_pend[i] <= m_filt[i];
        else if (m_filt[i] && !m_prev[i]) m_pend[i] <= 1'b1;
        else if (clr_valid && clr_mask[i]) m_pend[i] <= 1'b0;
      m_any <= m_pend != '0;
      m_id  <= lowest(m_pend);
      cyc   <= cyc + 1;
    end
  end

  always @(negedge clk) begin
    chk("model_ext_int_out", 32'(ext_int_out), 32'(m_pend));
    chk("model_int_any", 32'(int_any), 32'(m_any));
    chk("model_int_id", 32'(int_id), 32'(m_id));
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clear(input logic [N-1:0] m);
    clr_valid = 1; clr_mask = m;
    step(1);
    clr_valid = 0; clr_mask = '0;
  endtask

  int k, seen;
  logic [N-1:0] lines [3];
  logic [4:0]   nxt_id [3];

  initial begin
    step(3);
    chk("reset_ext", 32'(ext_int_out), 0);
    chk("reset_any", 32'(int_any), 0);
    chk("reset_id", 32'(int_id), 0);
    rst_n = 1;
    // edge line 3, unfiltered latency
    mode = 31'h8; pin_in[3] = 1;
    step(3); chk("lat_e3", 32'(ext_int_out[3]), 0);
    step(1); chk("lat_e4", 32'(ext_int_out[3]), 1); chk("lat_any_e4", 32'(int_any), 0);
    step(1); chk("lat_any_e5", 32'(int_any), 1); chk("lat_id_e5", 32'(int_id), 3);
    step(4); chk("hold_e9", 32'(ext_int_out[3]), 1);
    // clear, then clear coinciding with a new rise
    clear(31'h8); chk("clr3", 32'(ext_int_out[3]), 0);
    pin_in[3] = 0; step(4);
    pin_in[3] = 1; step(3);
    clear(31'h8); chk("set_wins", 32'(ext_int_out[3]), 1);
    clear(31'h8); step(1);
    // level line 7, 6-cycle pulse, clear ignored
    pin_in[7] = 1;
    for (int j = 1; j <= 14; j++) begin
      step(1);
      chk("level7", 32'(ext_int_out[7]), 32'(j >= 4 && j <= 9));
      if (j == 6) pin_in[7] = 0;
      clr_valid = (j == 5);
      clr_mask = (j == 5) ? 31'h80 : '0;
    end
    clr_valid = 0; clr_mask = '0;
    // priority walk
    mode = 31'h8 | 31'h4 | 31'h20 | 31'h4000_0000;
    pin_in = pin_in | 31'h4 | 31'h20 | 31'h4000_0000;
    step(5);
    chk("prio_any", 32'(int_any), 1); chk("prio_id", 32'(int_id), 2);
    lines = '{31'h4, 31'h20, 31'h4000_0000};
    nxt_id = '{5'd5, 5'd30, 5'd0};
    for (int j = 0; j < 3; j++) begin
      clear(lines[j]); step(1);
      chk("prio_walk_id", 32'(int_id), 32'(nxt_id[j]));
    end
    chk("prio_none_any", 32'(int_any), 0);
    // debounce: short pulse filtered, long pulse accepted
    deb_en = 1; pin_in = '0; mode = 31'h1;
    step(40);
    seen = 0;
    pin_in[0] = 1;
    for (int j = 0; j < 10; j++) begin step(1); seen |= int'(ext_int_out[0]); end
    pin_in[0] = 0;
    for (int j = 0; j < 40; j++) begin step(1); seen |= int'(ext_int_out[0]); end
    chk("deb_short", 32'(seen), 0);
    pin_in[0] = 1; k = 0;
    while (k < 36 && !ext_int_out[0]) begin step(1); k++; end
    chk("deb_long", 32'(ext_int_out[0]), 1);
    step(40 - k); pin_in[0] = 0;
    step(40); clear(31'h1); step(1);
    // all lines pending, async reset mid-cycle
    deb_en = 0; mode = '0; pin_in = '1;
    step(6); chk("all_pend", 32'(ext_int_out), 32'h7FFF_FFFF);
    step(1); chk("all_any", 32'(int_any), 1); chk("all_id", 32'(int_id), 0);
    #2 rst_n = 0; pin_in = '0;
    #1 chk("async_ext", 32'(ext_int_out), 0);
    chk("async_any", 32'(int_any), 0); chk("async_id", 32'(int_id), 0);
    #10 rst_n = 1;
    for (int j = 0; j < 8; j++) begin step(1); chk("post_rst_ext", 32'(ext_int_out), 0); end
    // pin high through reset release on an edge line
    rst_n = 0; mode = 31'h8; pin_in[3] = 1;
    step(2); rst_n = 1;
    step(3); chk("rstrel_e3", 32'(ext_int_out[3]), 0);
    step(1); chk("rstrel_e4", 32'(ext_int_out[3]), 1);
    step(3);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, miss);
    $finish;
  end
endmodule
